// File: rtl/float_res_mem_if.sv
// Harness-facing bundle of float_res_mem: run control, product input, result read port and status.
// master = test harness / multiplier side, slave = float_res_mem.
interface float_res_mem_if #(
  parameter int AW = 3
);
  logic          start;
  logic          res_valid;
  logic [31:0]   res_data;
  logic [AW-1:0] rd_addr;
  logic          inc_ptr;
  logic          op_valid;
  logic [31:0]   rd_data;
  logic [AW:0]   res_cnt;
  logic          busy;
  logic          done;
  logic          timeout;
  logic          stray;

  modport master (
    output start, res_valid, res_data, rd_addr,
    input  inc_ptr, op_valid, rd_data, res_cnt, busy, done, timeout, stray
  );

  modport slave (
    input  start, res_valid, res_data, rd_addr,
    output inc_ptr, op_valid, rd_data, res_cnt, busy, done, timeout, stray
  );
endinterface

// File: rtl/float_res_mem.sv
// float_res_mem: paces the operand store, captures FP products into an indexed RAM and flags
// completion/timeout/stray results. Define FLOAT_RES_CHK_EN to add the expected-product checker.
module float_res_mem #(
  parameter int DEPTH      = 8,
  parameter int AW         = 3,
  parameter int SETTLE_CYC = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic           clk,
  input  logic           reset,
  float_res_mem_if.slave bus
`ifdef FLOAT_RES_CHK_EN
  ,
  input  logic           exp_we,
  input  logic [AW-1:0]  exp_addr,
  input  logic [31:0]    exp_data,
  output logic [AW:0]    mism_cnt,
  output logic           mism
`endif
);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int SW = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;
  localparam logic [AW:0]   CNT_MAX  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] IDX_LAST = AW'(DEPTH - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [SW-1:0] SETTLE_LD = SW'(SETTLE_CYC);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_ISSUE  = 3'd2,
    S_WAIT   = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [TW-1:0] to_q, to_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          timeout_q, timeout_d;
  logic          stray_q, stray_d;
  logic          inc_ptr_q, op_valid_q, busy_q, done_q;
  logic [31:0]   rd_data_q;
  logic          capture_s, start_s;
  logic [31:0]   mem [DEPTH];

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    settle_d  = settle_q;
    to_d      = to_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    stray_d   = stray_q;
    capture_s = 1'b0;
    start_s   = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          start_s   = 1'b1;
          state_d   = S_SETTLE;
          settle_d  = SETTLE_LD;
          idx_d     = '0;
          cnt_d     = '0;
          timeout_d = 1'b0;
          stray_d   = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      // SETTLE lasts SETTLE_CYC cycles (at least one) before the operand pair is announced.
      S_SETTLE: begin
        if (settle_q <= SW'(1)) begin
          settle_d = '0;
          state_d  = S_ISSUE;
        end else begin
          settle_d = settle_q - SW'(1);
        end
      end
      S_ISSUE: begin
        to_d    = '0;
        state_d = S_WAIT;
      end
      // A product arriving on the last timeout count still wins over the abort.
      S_WAIT: begin
        if (bus.res_valid) begin
          capture_s = 1'b1;
          cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + (AW+1)'(1);
          if (idx_q == IDX_LAST) begin
            state_d = S_DONE;
          end else begin
            idx_d    = idx_q + AW'(1);
            settle_d = SETTLE_LD;
            state_d  = S_SETTLE;
          end
        end else if (to_q == TO_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          to_d = to_q + TW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (bus.res_valid && (state_q != S_WAIT)) begin
      stray_d = 1'b1;
    end else begin
      stray_d = stray_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      settle_q   <= '0;
      to_q       <= '0;
      cnt_q      <= '0;
      timeout_q  <= 1'b0;
      stray_q    <= 1'b0;
      inc_ptr_q  <= 1'b0;
      op_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      settle_q   <= settle_d;
      to_q       <= to_d;
      cnt_q      <= cnt_d;
      timeout_q  <= timeout_d;
      stray_q    <= stray_d;
      inc_ptr_q  <= capture_s;
      op_valid_q <= (state_d == S_ISSUE);
      busy_q     <= (state_d == S_SETTLE) || (state_d == S_ISSUE) || (state_d == S_WAIT);
      done_q     <= (state_d == S_DONE);
    end
  end

  // Result RAM has no reset; a capture in the reset cycle is dropped with the rest of the run.
  always_ff @(posedge clk) begin
    if (capture_s && !reset) begin
      mem[idx_q] <= bus.res_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem[bus.rd_addr];
    end
  end

  assign bus.inc_ptr  = inc_ptr_q;
  assign bus.op_valid = op_valid_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.res_cnt  = cnt_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.timeout  = timeout_q;
  assign bus.stray    = stray_q;

`ifdef FLOAT_RES_CHK_EN
  logic [31:0] exp_mem [DEPTH];
  logic [AW:0] mism_cnt_q, mism_cnt_d;
  logic        mism_q, mism_d;

  always_ff @(posedge clk) begin
    if (exp_we) begin
      exp_mem[exp_addr] <= exp_data;
    end
  end

  always_comb begin
    mism_cnt_d = mism_cnt_q;
    mism_d     = mism_q;
    if (start_s) begin
      mism_cnt_d = '0;
      mism_d     = 1'b0;
    end else if (capture_s && (bus.res_data != exp_mem[idx_q])) begin
      mism_cnt_d = (mism_cnt_q == CNT_MAX) ? mism_cnt_q : mism_cnt_q + (AW+1)'(1);
      mism_d     = 1'b1;
    end else begin
      mism_cnt_d = mism_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mism_cnt_q <= '0;
      mism_q     <= 1'b0;
    end else begin
      mism_cnt_q <= mism_cnt_d;
      mism_q     <= mism_d;
    end
  end

  assign mism_cnt = mism_cnt_q;
  assign mism     = mism_q;
`endif
endmodule

// File: tb/tb_float_res_mem.sv
// Scoreboard bench for float_res_mem: behavioural multiplier/operand-store model drives the DUT,
// expectations are queued at stimulus time and a separate monitor pops them on DUT output events.
module tb_float_res_mem;
  logic clk = 1'b0;
  logic reset;
  float_res_mem_if #(.AW(3)) bus ();

`ifdef FLOAT_RES_CHK_EN
  logic        exp_we;
  logic [2:0]  exp_addr;
  logic [31:0] exp_data;
  logic [3:0]  mism_cnt;
  logic        mism;
`endif

  float_res_mem #(.DEPTH(8), .AW(3), .SETTLE_CYC(2), .TIMEOUT(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef FLOAT_RES_CHK_EN
    ,
    .exp_we   (exp_we),
    .exp_addr (exp_addr),
    .exp_data (exp_data),
    .mism_cnt (mism_cnt),
    .mism     (mism)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Operand store model: table of A operands, 3-bit pointer advanced by inc_ptr.
  logic [31:0] opa_tab [8];
  logic [2:0]  op_ptr;
  always @(posedge clk) begin
    if (reset) op_ptr <= 3'd0;
    else if (bus.inc_ptr) op_ptr <= op_ptr + 3'd1;
  end

  bit rd_req = 1'b0;
  bit rd_vld_pipe = 1'b0;
  always @(posedge clk) rd_vld_pipe <= rd_req;

  // Scoreboard queues and reference state.
  logic [31:0] exp_op_q [$];
  logic [3:0]  exp_cnt_q [$];
  logic [31:0] exp_rd_q [$];
  logic [31:0] ref_mem [8];
  int          run_idx, ptr_ref, n_ops, n_resp, resp_cd, corrupt;
  bit          pattern;
  logic [31:0] pend_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got an output event, expected none", name);
  endtask

  initial begin : monitor
    logic [31:0] e;
    logic [3:0]  c;
    forever begin
      @(negedge clk);
      if (bus.op_valid === 1'b1) begin
        if (exp_op_q.size() == 0) unexpected("op_valid_extra");
        else begin
          e = exp_op_q.pop_front();
          chk("operand_at_op_valid", opa_tab[op_ptr], e);
        end
      end
      if (bus.inc_ptr === 1'b1) begin
        if (exp_cnt_q.size() == 0) unexpected("inc_ptr_extra");
        else begin
          c = exp_cnt_q.pop_front();
          chk("res_cnt_at_inc_ptr", 32'(bus.res_cnt), 32'(c));
        end
      end
      if (rd_vld_pipe) begin
        if (exp_rd_q.size() == 0) unexpected("rd_data_extra");
        else begin
          e = exp_rd_q.pop_front();
          chk("rd_data", bus.rd_data, e);
        end
      end
    end
  end

  // One clock: drive inputs just after the edge; multiplier answers 3 cycles after op_valid.
  task automatic cycle();
    @(posedge clk);
    #1;
    bus.start     = 1'b0;
    bus.res_valid = 1'b0;
    rd_req        = 1'b0;
    if (resp_cd > 0) begin
      resp_cd--;
      if (resp_cd == 0) begin
        bus.res_valid    = 1'b1;
        bus.res_data     = pend_data;
        ref_mem[run_idx] = pend_data;
        run_idx++;
        exp_cnt_q.push_back(4'(run_idx));
        ptr_ref = (ptr_ref + 1) % 8;
        if (run_idx < 8) exp_op_q.push_back(opa_tab[ptr_ref]);
      end
    end
    if (bus.op_valid === 1'b1) begin
      n_ops++;
      if (n_ops <= n_resp) begin
        resp_cd   = 3;
        pend_data = pattern ? (32'h3F80_0000 + 32'(run_idx)) : $urandom();
        if (run_idx == corrupt) pend_data = 32'h3F80_0000;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_flags"}, 32'({bus.inc_ptr, bus.op_valid, bus.busy, bus.done, bus.timeout, bus.stray}), 32'd0);
    chk({tag, "_res_cnt"}, 32'(bus.res_cnt), 32'd0);
    chk({tag, "_rd_data"}, bus.rd_data, 32'd0);
  endtask

  task automatic readback();
    for (int a = 0; a < 8; a++) begin
      bus.rd_addr = 3'(a);
      rd_req = 1'b1;
      exp_rd_q.push_back(ref_mem[a]);
      cycle();
    end
    cycle();
    cycle();
    chk("rd_queue_drained", 32'(exp_rd_q.size()), 32'd0);
  endtask

  task automatic do_run(input int resp, input bit pat, input int corr, input bit stray_settle,
                        input int abort_at);
    int lat;
    int budget;
    int last_op;
    n_resp = resp; pattern = pat; corrupt = corr;
    n_ops = 0; run_idx = 0; resp_cd = 0;
    bus.start = 1'b1;
    exp_op_q.push_back(opa_tab[ptr_ref]);
    lat = 0;
    do begin
      cycle();
      lat++;
      if (stray_settle && lat == 1) begin
        bus.res_valid = 1'b1;
        bus.res_data  = 32'hDEAD_BEEF;
      end
    end while (bus.op_valid !== 1'b1 && lat < 20);
    chk("first_op_valid_latency", 32'(lat), 32'd3);
    chk("busy_in_issue", 32'(bus.busy), 32'd1);
    last_op = 0;
    budget = 0;
    while (bus.done !== 1'b1 && budget < 3000) begin
      cycle();
      budget++;
      if (bus.op_valid === 1'b1) last_op = budget;
      if (abort_at > 0 && n_ops == abort_at) begin
        cycle();
        reset = 1'b1;
        cycle();
        check_reset_outputs("mid_run_reset");
        reset = 1'b0;
        ptr_ref = 0; resp_cd = 0;
        exp_op_q.delete();
        exp_cnt_q.delete();
        return;
      end
    end
    chk("done", 32'(bus.done), 32'd1);
    chk("busy_in_done", 32'(bus.busy), 32'd0);
    chk("res_cnt_final", 32'(bus.res_cnt), 32'((resp < 8) ? resp : 8));
    chk("timeout_flag", 32'(bus.timeout), 32'(resp < 8));
    chk("stray_flag", 32'(bus.stray), 32'(stray_settle));
    if (resp < 8) chk("timeout_latency", 32'(budget - last_op), 32'd65);
    cycle();
    cycle();
    chk("inc_ptr_all_seen", 32'(exp_cnt_q.size()), 32'd0);
    chk("op_valid_all_seen", 32'(exp_op_q.size()), 32'd0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    for (int i = 0; i < 8; i++) opa_tab[i] = 32'h3fc4_d2a5 + 32'(i) * 32'h0010_0000;
    reset = 1'b1;
    bus.start = 1'b0; bus.res_valid = 1'b0; bus.res_data = 32'd0; bus.rd_addr = 3'd0;
    ptr_ref = 0; resp_cd = 0; n_ops = 0; n_resp = 0; run_idx = 0; corrupt = -1; pattern = 1'b0;
`ifdef FLOAT_RES_CHK_EN
    exp_we = 1'b0; exp_addr = 3'd0; exp_data = 32'd0;
`endif
    cycle();
    cycle();
    check_reset_outputs("reset");
`ifdef FLOAT_RES_CHK_EN
    for (int i = 0; i < 8; i++) begin
      exp_we = 1'b1; exp_addr = 3'(i); exp_data = 32'h3F80_0000 + 32'(i);
      cycle();
    end
    exp_we = 1'b0;
`endif
    reset = 1'b0;
    cycle();

    do_run(8, 1'b1, -1, 1'b0, 0);            // pattern run: RAM[i] = 0x3F800000+i
    readback();
`ifdef FLOAT_RES_CHK_EN
    chk("mism_cnt_clean", 32'(mism_cnt), 32'd0);
`endif
    do_run(8, 1'b0, -1, 1'b0, 0);            // back-to-back from DONE, random products
    readback();
    do_run(8, 1'b1, 6, 1'b0, 0);             // result 6 corrupted
    readback();
`ifdef FLOAT_RES_CHK_EN
    chk("mism_cnt_corrupt", 32'(mism_cnt), 32'd1);
    chk("mism_corrupt", 32'(mism), 32'd1);
`endif
    do_run(8, 1'b1, -1, 1'b0, 0);
`ifdef FLOAT_RES_CHK_EN
    chk("mism_cnt_rerun", 32'(mism_cnt), 32'd0);
    chk("mism_rerun", 32'(mism), 32'd0);
`endif
    do_run(2, 1'b0, -1, 1'b0, 0);            // multiplier silent after two products
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    ptr_ref = 0;
    cycle();
    readback();

    bus.res_valid = 1'b1;                    // stray product in IDLE
    bus.res_data  = 32'hDEAD_BEEF;
    cycle();
    cycle();
    chk("stray_idle", 32'(bus.stray), 32'd1);
    chk("stray_idle_res_cnt", 32'(bus.res_cnt), 32'd0);
    readback();

    do_run(8, 1'b0, -1, 1'b1, 0);            // stray product in SETTLE
    readback();
    do_run(4, 1'b0, -1, 1'b0, 5);            // reset while waiting on index 4
    cycle();
    do_run(8, 1'b0, -1, 1'b0, 0);            // clean run after the abort
    readback();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
